// File: rtl/mips_pkg.sv
// Shared encodings for the pipeline control unit: opcodes, functs, ALU codes,
// mux selects and the per-stage control bundles.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_R31   = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_PC8  = 2'b10;
  localparam logic [1:0] RES_HILO = 2'b11;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  typedef enum logic {MDU_IDLE, MDU_BUSY} mdu_state_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [2:0] alu_control;
    logic       mdu_start;
    logic       mdu_div;
    logic [1:0] result_src;
    logic       hi_sel;
  } ctrl_e_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [1:0] result_src;
    logic       hi_sel;
  } ctrl_m_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       hi_sel;
  } ctrl_w_t;

  typedef struct packed {
    ctrl_e_t e;
    logic    beq;
    logic    bne;
    logic    jump;
    logic    jr;
    logic    uses_rs;
    logic    uses_rt;
    logic    mdu_op;
  } dec_t;

  function automatic logic [2:0] alu_for_funct(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_if.sv
// Datapath <-> control/hazard unit signal bundle. The datapath is the master,
// the control unit the slave.
interface pipe_ctrl_mdu_if #(
  parameter int REGW = 5
);
  logic [5:0]      OpD;
  logic [5:0]      FunctD;
  logic [REGW-1:0] RsD, RtD, RsE, RtE;
  logic [REGW-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic            EqualD;

  logic            PCSrcD, JumpD, JrD;
  logic            ALUSrcE;
  logic [1:0]      RegDstE;
  logic [2:0]      ALUControlE;
  logic            MduStartE, MduDivE;
  logic            RegWriteE, RegWriteM, RegWriteW;
  logic            MemtoRegE, MemtoRegM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcW;
  logic            HiSelW;
  logic            ForwardAD, ForwardBD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE;
  logic            MduBusy;

  modport master (
    output OpD, FunctD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, EqualD,
    input  PCSrcD, JumpD, JrD, ALUSrcE, RegDstE, ALUControlE, MduStartE, MduDivE,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
    input  ResultSrcW, HiSelW, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    input  StallF, StallD, FlushD, FlushE, MduBusy
  );

  modport slave (
    input  OpD, FunctD, RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, EqualD,
    output PCSrcD, JumpD, JrD, ALUSrcE, RegDstE, ALUControlE, MduStartE, MduDivE,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, MemWriteM,
    output ResultSrcW, HiSelW, ForwardAD, ForwardBD, ForwardAE, ForwardBE,
    output StallF, StallD, FlushD, FlushE, MduBusy
  );
endinterface

// File: rtl/flopr.sv
// Resettable pipeline register.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/floprc.sv
// Resettable pipeline register with a synchronous clear for bubble insertion.
module floprc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset || clear) q <= '0;
    else                q <= d;
  end
endmodule

// File: rtl/mdu_fsm.sv
// Multiply/divide occupancy tracker: BUSY lasts exactly the selected latency
// after the start pulse, and busy also covers the start cycle itself.
module mdu_fsm
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CNTW     = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic mdu_start,
  input  logic mdu_div,
  output logic mdu_busy
);
  mdu_state_t      state_reg, state_next;
  logic [CNTW-1:0] count_reg, count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= MDU_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      MDU_IDLE: begin
        if (mdu_start) begin
          state_next = MDU_BUSY;
          count_next = mdu_div ? CNTW'(DIV_LAT - 1) : CNTW'(MULT_LAT - 1);
        end
      end
      MDU_BUSY: begin
        if (count_reg == '0) state_next = MDU_IDLE;
        else                 count_next = count_reg - CNTW'(1);
      end
      default: state_next = MDU_IDLE;
    endcase
  end

  assign mdu_busy = (state_reg == MDU_BUSY) | mdu_start;
endmodule

// File: rtl/pipe_ctrl_mdu.sv
// Control and hazard unit for the 5-stage MIPS pipeline: decode, D/E-E/M-M/W
// control registers, forwarding, load-use/branch/MDU stalls and flushes.
module pipe_ctrl_mdu
  import mips_pkg::*;
#(
  parameter int REGW       = 5,
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 32,
  parameter int CNTW       = 6,
  parameter int DELAY_SLOT = 0
) (
  input  logic           clk,
  input  logic           reset,
  pipe_ctrl_mdu_if.slave bus
);
  localparam logic SQUASH = (DELAY_SLOT == 0);

  dec_t    dec;
  ctrl_e_t ctrl_e_reg;
  ctrl_m_t ctrl_m_reg, ctrl_m_next;
  ctrl_w_t ctrl_w_reg, ctrl_w_next;
  logic    mdu_busy;
  logic    lwstall, branchstall, mdustall, stall;
  logic    pcsrc, rs_hit_e, rt_hit_e, rs_hit_m, rt_hit_m;

  // Register $0 is hard-wired, so it never creates a dependency.
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  always_comb begin
    dec = '0;
    case (bus.OpD)
      OP_RTYPE: begin
        case (bus.FunctD)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            dec.e.reg_write   = 1'b1;
            dec.e.reg_dst     = RD_RD;
            dec.e.alu_control = alu_for_funct(bus.FunctD);
            dec.uses_rs       = 1'b1;
            dec.uses_rt       = 1'b1;
          end
          FN_MULT, FN_DIV: begin
            dec.e.mdu_start = 1'b1;
            dec.e.mdu_div   = (bus.FunctD == FN_DIV);
            dec.uses_rs     = 1'b1;
            dec.uses_rt     = 1'b1;
            dec.mdu_op      = 1'b1;
          end
          FN_MFHI, FN_MFLO: begin
            dec.e.reg_write  = 1'b1;
            dec.e.reg_dst    = RD_RD;
            dec.e.result_src = RES_HILO;
            dec.e.hi_sel     = (bus.FunctD == FN_MFHI);
            dec.mdu_op       = 1'b1;
          end
          FN_JR: begin
            dec.jr      = 1'b1;
            dec.uses_rs = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        dec.e.reg_write   = 1'b1;
        dec.e.mem_to_reg  = 1'b1;
        dec.e.alu_src     = 1'b1;
        dec.e.alu_control = ALU_ADD;
        dec.e.reg_dst     = RD_RT;
        dec.e.result_src  = RES_MEM;
        dec.uses_rs       = 1'b1;
      end
      OP_SW: begin
        dec.e.mem_write   = 1'b1;
        dec.e.alu_src     = 1'b1;
        dec.e.alu_control = ALU_ADD;
        dec.uses_rs       = 1'b1;
        dec.uses_rt       = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec.beq           = (bus.OpD == OP_BEQ);
        dec.bne           = (bus.OpD == OP_BNE);
        dec.e.alu_control = ALU_SUB;
        dec.uses_rs       = 1'b1;
        dec.uses_rt       = 1'b1;
      end
      OP_ADDI, OP_ORI: begin
        dec.e.reg_write   = 1'b1;
        dec.e.alu_src     = 1'b1;
        dec.e.alu_control = (bus.OpD == OP_ORI) ? ALU_OR : ALU_ADD;
        dec.uses_rs       = 1'b1;
      end
      OP_J: dec.jump = 1'b1;
      OP_JAL: begin
        dec.jump         = 1'b1;
        dec.e.reg_write  = 1'b1;
        dec.e.reg_dst    = RD_R31;
        dec.e.result_src = RES_PC8;
      end
      default: ;
    endcase
    // Holding decode at zero keeps every output quiet while reset is asserted.
    if (reset) dec = '0;
  end

  floprc #(.WIDTH($bits(ctrl_e_t))) de_reg (
    .clk(clk), .reset(reset), .clear(stall), .d(dec.e), .q(ctrl_e_reg)
  );

  assign ctrl_m_next = '{reg_write:  ctrl_e_reg.reg_write,
                         mem_to_reg: ctrl_e_reg.mem_to_reg,
                         mem_write:  ctrl_e_reg.mem_write,
                         result_src: ctrl_e_reg.result_src,
                         hi_sel:     ctrl_e_reg.hi_sel};

  flopr #(.WIDTH($bits(ctrl_m_t))) em_reg (
    .clk(clk), .reset(reset), .d(ctrl_m_next), .q(ctrl_m_reg)
  );

  assign ctrl_w_next = '{reg_write:  ctrl_m_reg.reg_write,
                         result_src: ctrl_m_reg.result_src,
                         hi_sel:     ctrl_m_reg.hi_sel};

  flopr #(.WIDTH($bits(ctrl_w_t))) mw_reg (
    .clk(clk), .reset(reset), .d(ctrl_w_next), .q(ctrl_w_reg)
  );

  mdu_fsm #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNTW(CNTW)) u_mdu (
    .clk(clk), .reset(reset),
    .mdu_start(ctrl_e_reg.mdu_start), .mdu_div(ctrl_e_reg.mdu_div),
    .mdu_busy(mdu_busy)
  );

  assign rs_hit_e = dec.uses_rs & hit(bus.RsD, bus.WriteRegE);
  assign rt_hit_e = dec.uses_rt & hit(bus.RtD, bus.WriteRegE);
  assign rs_hit_m = dec.uses_rs & hit(bus.RsD, bus.WriteRegM);
  assign rt_hit_m = dec.uses_rt & hit(bus.RtD, bus.WriteRegM);

  assign lwstall = ctrl_e_reg.mem_to_reg &
                   ((dec.uses_rs & hit(bus.RsD, bus.RtE)) | (dec.uses_rt & hit(bus.RtD, bus.RtE)));
  // The D-stage compare sees ALUOutM, so only a load result still in M is too late.
  assign branchstall = (dec.beq | dec.bne | dec.jr) &
                       ((ctrl_e_reg.reg_write & (rs_hit_e | rt_hit_e)) |
                        (ctrl_m_reg.mem_to_reg & (rs_hit_m | rt_hit_m)));
  assign mdustall = mdu_busy & dec.mdu_op;
  assign stall    = lwstall | branchstall | mdustall;
  assign pcsrc    = (dec.beq & bus.EqualD) | (dec.bne & ~bus.EqualD);

  assign bus.PCSrcD      = pcsrc;
  assign bus.JumpD       = dec.jump;
  assign bus.JrD         = dec.jr;
  assign bus.StallF      = stall;
  assign bus.StallD      = stall;
  assign bus.FlushE      = stall;
  assign bus.FlushD      = SQUASH & ~stall & (pcsrc | dec.jump | dec.jr);
  assign bus.MduBusy     = mdu_busy;

  assign bus.ALUSrcE     = ctrl_e_reg.alu_src;
  assign bus.RegDstE     = ctrl_e_reg.reg_dst;
  assign bus.ALUControlE = ctrl_e_reg.alu_control;
  assign bus.MduStartE   = ctrl_e_reg.mdu_start;
  assign bus.MduDivE     = ctrl_e_reg.mdu_div;
  assign bus.RegWriteE   = ctrl_e_reg.reg_write;
  assign bus.MemtoRegE   = ctrl_e_reg.mem_to_reg;
  assign bus.RegWriteM   = ctrl_m_reg.reg_write;
  assign bus.MemtoRegM   = ctrl_m_reg.mem_to_reg;
  assign bus.MemWriteM   = ctrl_m_reg.mem_write;
  assign bus.RegWriteW   = ctrl_w_reg.reg_write;
  assign bus.ResultSrcW  = ctrl_w_reg.result_src;
  assign bus.HiSelW      = ctrl_w_reg.hi_sel;

  assign bus.ForwardAD = ctrl_m_reg.reg_write & hit(bus.RsD, bus.WriteRegM);
  assign bus.ForwardBD = ctrl_m_reg.reg_write & hit(bus.RtD, bus.WriteRegM);
  assign bus.ForwardAE = (ctrl_m_reg.reg_write & hit(bus.RsE, bus.WriteRegM)) ? FWD_M :
                         (ctrl_w_reg.reg_write & hit(bus.RsE, bus.WriteRegW)) ? FWD_W : FWD_RF;
  assign bus.ForwardBE = (ctrl_m_reg.reg_write & hit(bus.RtE, bus.WriteRegM)) ? FWD_M :
                         (ctrl_w_reg.reg_write & hit(bus.RtE, bus.WriteRegW)) ? FWD_W : FWD_RF;
endmodule

// File: tb/tb_pipe_ctrl_mdu.sv
module tb_pipe_ctrl_mdu;
  import mips_pkg::*;

  typedef enum int {
    S_FAE, S_FBE, S_FAD, S_FBD, S_STALLF, S_STALLD, S_FLUSHE, S_FLUSHD, S_FLUSHD_DS,
    S_PCSRC, S_JUMP, S_JR, S_MSTART, S_MDIV, S_BUSY, S_RESW, S_HISELW,
    S_REGWE, S_REGWM, S_REGWW, S_MEMTOREGE, S_MEMTOREGM, S_ALUSRCE, S_REGDSTE, S_ALUCTLE
  } sig_e;

  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  pipe_ctrl_mdu_if #(.REGW(5)) bus ();
  pipe_ctrl_mdu_if #(.REGW(5)) bus_ds ();

  pipe_ctrl_mdu #(.REGW(5), .MULT_LAT(4), .DIV_LAT(32), .CNTW(6), .DELAY_SLOT(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  pipe_ctrl_mdu #(.REGW(5), .MULT_LAT(4), .DIV_LAT(32), .CNTW(6), .DELAY_SLOT(1)) dut_ds (
    .clk(clk), .reset(reset), .bus(bus_ds)
  );

  assign bus_ds.OpD = bus.OpD;           assign bus_ds.FunctD = bus.FunctD;
  assign bus_ds.RsD = bus.RsD;           assign bus_ds.RtD = bus.RtD;
  assign bus_ds.RsE = bus.RsE;           assign bus_ds.RtE = bus.RtE;
  assign bus_ds.WriteRegE = bus.WriteRegE;
  assign bus_ds.WriteRegM = bus.WriteRegM;
  assign bus_ds.WriteRegW = bus.WriteRegW;
  assign bus_ds.EqualD = bus.EqualD;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] value(input sig_e s);
    case (s)
      S_FAE:       return 8'(bus.ForwardAE);
      S_FBE:       return 8'(bus.ForwardBE);
      S_FAD:       return 8'(bus.ForwardAD);
      S_FBD:       return 8'(bus.ForwardBD);
      S_STALLF:    return 8'(bus.StallF);
      S_STALLD:    return 8'(bus.StallD);
      S_FLUSHE:    return 8'(bus.FlushE);
      S_FLUSHD:    return 8'(bus.FlushD);
      S_FLUSHD_DS: return 8'(bus_ds.FlushD);
      S_PCSRC:     return 8'(bus.PCSrcD);
      S_JUMP:      return 8'(bus.JumpD);
      S_JR:        return 8'(bus.JrD);
      S_MSTART:    return 8'(bus.MduStartE);
      S_MDIV:      return 8'(bus.MduDivE);
      S_BUSY:      return 8'(bus.MduBusy);
      S_RESW:      return 8'(bus.ResultSrcW);
      S_HISELW:    return 8'(bus.HiSelW);
      S_REGWE:     return 8'(bus.RegWriteE);
      S_REGWM:     return 8'(bus.RegWriteM);
      S_REGWW:     return 8'(bus.RegWriteW);
      S_MEMTOREGE: return 8'(bus.MemtoRegE);
      S_MEMTOREGM: return 8'(bus.MemtoRegM);
      S_ALUSRCE:   return 8'(bus.ALUSrcE);
      S_REGDSTE:   return 8'(bus.RegDstE);
      S_ALUCTLE:   return 8'(bus.ALUControlE);
      default:     return 8'hFF;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [7:0] got;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        got = value(sb[i].sig);
        checks++;
        if (got === 8'(sb[i].val)) begin
          passes++;
          $display("cyc %0d %s = %0d ok", cyc, sb[i].name, got);
        end else begin
          $display("FAIL %s cyc=%0d got=%0d expected=%0d", sb[i].name, cyc, got, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int d, input sig_e s, input int v, input string n);
    exp_t e;
    e.cyc = cyc + d; e.sig = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dset(input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic eq);
    bus.OpD = op; bus.FunctD = fn; bus.RsD = rs; bus.RtD = rt; bus.EqualD = eq;
  endtask

  task automatic eset(input logic [4:0] rse, input logic [4:0] rte,
                      input logic [4:0] wre, input logic [4:0] wrm, input logic [4:0] wrw);
    bus.RsE = rse; bus.RtE = rte; bus.WriteRegE = wre; bus.WriteRegM = wrm; bus.WriteRegW = wrw;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);

    reset = 1'b1;
    step(); step();
    dset(OP_JAL, 6'h00, 5'd0, 5'd0, 1'b1);
    #1;
    chk(0, S_JUMP, 0, "rst_jump"); chk(0, S_FLUSHD, 0, "rst_flushd");
    chk(0, S_REGWE, 0, "rst_regwe"); chk(0, S_BUSY, 0, "rst_busy");
    chk(0, S_STALLD, 0, "rst_stalld"); chk(0, S_FAE, 0, "rst_fae");
    step();
    reset = 1'b0;
    #1;
    chk(0, S_JUMP, 1, "jal_jump"); chk(0, S_FLUSHD, 1, "jal_flushd");
    chk(0, S_FLUSHD_DS, 0, "jal_flushd_ds");
    step();
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    chk(0, S_REGDSTE, 2, "jal_regdste"); chk(0, S_REGWE, 1, "jal_regwe");
    chk(2, S_RESW, 2, "jal_resw");
    step(); step(); step();

    do_reset();
    dset(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 1'b0);
    step();
    eset(5'd1, 5'd2, 5'd3, 5'd0, 5'd0);
    dset(OP_RTYPE, FN_SUB, 5'd3, 5'd4, 1'b0);
    chk(0, S_REGWE, 1, "add_regwe"); chk(0, S_REGDSTE, 1, "add_regdste");
    chk(0, S_ALUCTLE, 2, "add_aluctl"); chk(0, S_ALUSRCE, 0, "add_alusrc");
    chk(0, S_STALLD, 0, "add_sub_nostall");
    step();
    eset(5'd3, 5'd4, 5'd5, 5'd3, 5'd0);
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    chk(0, S_FAE, 2, "fwd_ae_m"); chk(0, S_FBE, 0, "fwd_be_none");
    chk(0, S_ALUCTLE, 6, "sub_aluctl"); chk(0, S_REGWM, 1, "add_regwm");
    step();
    eset(5'd3, 5'd5, 5'd0, 5'd5, 5'd3);
    dset(OP_BEQ, 6'h00, 5'd5, 5'd7, 1'b0);
    chk(0, S_FAE, 1, "fwd_ae_w"); chk(0, S_FBE, 2, "fwd_be_m");
    chk(0, S_REGWW, 1, "add_regww"); chk(0, S_FAD, 1, "fwd_ad");
    chk(0, S_FBD, 0, "fwd_bd_none"); chk(0, S_STALLD, 0, "beq_nostall");
    chk(0, S_PCSRC, 0, "beq_ne_pcsrc");
    step();

    do_reset();
    dset(OP_RTYPE, FN_ADD, 5'd1, 5'd2, 1'b0);
    step();
    eset(5'd1, 5'd2, 5'd0, 5'd0, 5'd0);
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    dset(OP_BEQ, 6'h00, 5'd0, 5'd0, 1'b1);
    chk(0, S_REGWM, 1, "r0_regwm"); chk(0, S_FAE, 0, "r0_fae"); chk(0, S_FBE, 0, "r0_fbe");
    chk(0, S_FAD, 0, "r0_fad"); chk(0, S_PCSRC, 1, "beq_eq_pcsrc");
    chk(0, S_FLUSHD, 1, "beq_flushd"); chk(0, S_FLUSHD_DS, 0, "beq_flushd_ds");
    step();

    do_reset();
    dset(OP_LW, 6'h00, 5'd1, 5'd2, 1'b0);
    step();
    eset(5'd1, 5'd2, 5'd2, 5'd0, 5'd0);
    dset(OP_RTYPE, FN_ADD, 5'd2, 5'd5, 1'b0);
    chk(0, S_STALLF, 1, "lw_stallf"); chk(0, S_STALLD, 1, "lw_stalld");
    chk(0, S_FLUSHE, 1, "lw_flushe"); chk(0, S_MEMTOREGE, 1, "lw_memtorege");
    chk(0, S_ALUSRCE, 1, "lw_alusrc"); chk(0, S_FLUSHD, 0, "lw_flushd");
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd2, 5'd0);
    chk(0, S_STALLD, 0, "lw_stall_done"); chk(0, S_REGWE, 0, "lw_bubble_regwe");
    chk(0, S_MEMTOREGM, 1, "lw_memtoregm");
    step();
    eset(5'd2, 5'd5, 5'd4, 5'd0, 5'd2);
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    chk(0, S_FAE, 1, "lw_fwd_w"); chk(0, S_REGWE, 1, "lw_add_regwe");
    chk(0, S_REGWM, 0, "lw_bubble_regwm");
    step();

    do_reset();
    dset(OP_LW, 6'h00, 5'd1, 5'd2, 1'b0);
    step();
    eset(5'd1, 5'd2, 5'd2, 5'd0, 5'd0);
    dset(OP_J, 6'h00, 5'd2, 5'd2, 1'b0);
    chk(0, S_STALLD, 0, "j_nostall"); chk(0, S_JUMP, 1, "j_jump");
    chk(0, S_FLUSHD, 1, "j_flushd"); chk(0, S_FLUSHD_DS, 0, "j_flushd_ds");
    step();

    do_reset();
    dset(OP_LW, 6'h00, 5'd0, 5'd7, 1'b0);
    step();
    eset(5'd0, 5'd7, 5'd7, 5'd0, 5'd0);
    dset(OP_RTYPE, FN_ADD, 5'd2, 5'd3, 1'b0);
    chk(0, S_STALLD, 0, "add_after_lw_nostall");
    step();
    eset(5'd2, 5'd3, 5'd1, 5'd7, 5'd0);
    dset(OP_BEQ, 6'h00, 5'd4, 5'd1, 1'b1);
    chk(0, S_STALLD, 1, "br_stall_e"); chk(0, S_FLUSHE, 1, "br_flushe");
    chk(0, S_FLUSHD, 0, "br_stall_flushd"); chk(0, S_PCSRC, 1, "br_stall_pcsrc");
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd1, 5'd7);
    chk(0, S_STALLD, 0, "br_released"); chk(0, S_FBD, 1, "br_fwd_bd");
    chk(0, S_FLUSHD, 1, "br_flushd");
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd1);
    dset(OP_BNE, 6'h00, 5'd4, 5'd1, 1'b1);
    chk(0, S_PCSRC, 0, "bne_eq_pcsrc"); chk(0, S_FLUSHD, 0, "bne_eq_flushd");
    step();

    do_reset();
    dset(OP_LW, 6'h00, 5'd0, 5'd7, 1'b0);
    step();
    eset(5'd0, 5'd7, 5'd7, 5'd0, 5'd0);
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd7, 5'd0);
    dset(OP_RTYPE, FN_JR, 5'd7, 5'd0, 1'b0);
    chk(0, S_STALLD, 1, "jr_stall_m"); chk(0, S_JR, 1, "jr_jr");
    chk(0, S_FLUSHD, 0, "jr_stall_flushd");
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd7);
    chk(0, S_STALLD, 0, "jr_released"); chk(0, S_FLUSHD, 1, "jr_flushd");
    step();

    do_reset();
    dset(OP_RTYPE, FN_MULT, 5'd1, 5'd2, 1'b0);
    chk(0, S_BUSY, 0, "mult_idle");
    step();
    eset(5'd1, 5'd2, 5'd0, 5'd0, 5'd0);
    dset(OP_RTYPE, FN_MFLO, 5'd0, 5'd0, 1'b0);
    chk(0, S_MSTART, 1, "mult_start"); chk(0, S_MDIV, 0, "mult_div");
    for (int k = 0; k <= 5; k++) begin
      chk(0, S_STALLD, (k < 5) ? 1 : 0, $sformatf("mflo_stall_%0d", k));
      chk(0, S_BUSY, (k < 5) ? 1 : 0, $sformatf("mult_busy_%0d", k));
      if (k > 0) chk(0, S_MSTART, 0, $sformatf("mult_nostart_%0d", k));
      if (k == 5) begin
        chk(1, S_REGWE, 1, "mflo_in_e");
        chk(3, S_RESW, 3, "mflo_resw");
        chk(3, S_HISELW, 0, "mflo_hisel");
      end
      if (k < 5) step();
    end
    step();
    eset(5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    step(); step(); step();

    do_reset();
    dset(OP_RTYPE, FN_DIV, 5'd1, 5'd2, 1'b0);
    step();
    dset(OP_RTYPE, FN_MULT, 5'd3, 5'd4, 1'b0);
    chk(0, S_MDIV, 1, "div_div");
    for (int k = 0; k <= 33; k++) begin
      chk(0, S_STALLD, (k < 33) ? 1 : 0, $sformatf("div_stall_%0d", k));
      chk(0, S_MSTART, (k == 0) ? 1 : 0, $sformatf("div_start_%0d", k));
      step();
    end
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    chk(0, S_MSTART, 1, "mult2_start"); chk(0, S_MDIV, 0, "mult2_div");
    step();
    chk(0, S_MSTART, 0, "mult2_single"); chk(0, S_BUSY, 1, "mult2_busy");
    step();

    do_reset();
    dset(OP_RTYPE, FN_MULT, 5'd1, 5'd2, 1'b0);
    step();
    dset(OP_RTYPE, FN_MFHI, 5'd0, 5'd0, 1'b0);
    step(); step();
    chk(0, S_BUSY, 1, "pre_rst_busy");
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.MduBusy === 1'b0 && bus.StallF === 1'b0 && bus.FlushE === 1'b0) begin
      passes++;
      $display("cyc %0d rst_abort_direct busy=%0d stallf=%0d flushe=%0d ok",
               cyc, bus.MduBusy, bus.StallF, bus.FlushE);
    end else begin
      $display("FAIL rst_abort_direct cyc=%0d busy=%0d stallf=%0d flushe=%0d",
               cyc, bus.MduBusy, bus.StallF, bus.FlushE);
    end
    chk(0, S_BUSY, 0, "rst_abort_busy"); chk(0, S_STALLD, 0, "rst_abort_stall");
    chk(0, S_MSTART, 0, "rst_abort_start"); chk(0, S_REGWE, 0, "rst_abort_regwe");
    chk(1, S_REGWE, 1, "mfhi_after_rst_e");
    chk(3, S_HISELW, 1, "mfhi_hisel");
    step();
    dset(6'h00, 6'h00, 5'd0, 5'd0, 1'b0);
    step(); step(); step(); step();

    foreach (sb[i]) begin
      checks++;
      $display("FAIL %s never_checked due=%0d now=%0d", sb[i].name, sb[i].cyc, cyc);
    end
    $display("%0d/%0d checks passed", passes, checks);
    if (passes == checks) $display("PASS");
    else                  $display("FAIL %0d checks failed", checks - passes);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_mdu.md
Name: pipe_ctrl_mdu

Overview:
Next-generation control and hazard unit for the 5-stage MIPS pipeline. Decodes the D-stage instruction and carries control fields through the D/E, E/M and M/W registers. Resolves forwarding, load-use stalls and branch stalls, and adds bne/jal/jr support and an optional branch delay slot. Tracks a multi-cycle multiply/divide unit (MDU) with a busy FSM and stalls mfhi/mflo and back-to-back mult/div until HI/LO are valid.

Parameters:
REGW, 5, register-index width
MULT_LAT, 4, mult busy cycles (>=1)
DIV_LAT, 32, div busy cycles (>=1)
CNTW, 6, MDU counter width; must hold max(MULT_LAT, DIV_LAT)-1
DELAY_SLOT, 0, 1 = never squash the instruction after a taken branch or jump

Ports:
clk in 1 clock
reset in 1 synchronous, active-high reset
OpD in 6 D-stage opcode
FunctD in 6 D-stage funct
RsD, RtD, RsE, RtE in REGW each; source register indices
WriteRegE, WriteRegM, WriteRegW in REGW each; destination register indices
EqualD in 1 D-stage comparator result (forwarded operands)
PCSrcD out 1 taken beq/bne
JumpD out 1 j/jal
JrD out 1 jr
ALUSrcE out 1 E-stage ALU B select
RegDstE out 2 00 rt, 01 rd, 10 r31
ALUControlE out 3 010 add, 110 sub, 000 and, 001 or, 111 slt
MduStartE out 1 one-cycle MDU start pulse
MduDivE out 1 1 = div, 0 = mult; valid with MduStartE
RegWriteE, RegWriteM, RegWriteW out 1 each
MemtoRegE, MemtoRegM out 1 each
MemWriteM out 1
ResultSrcW out 2 00 ALU, 01 mem, 10 PC+8, 11 HI/LO
HiSelW out 1 1 = HI, 0 = LO
ForwardAD, ForwardBD out 1 each; take the ALUOutM operand at the D-stage compare
ForwardAE, ForwardBE out 2 each; 10 M, 01 W, 00 RF
StallF, StallD, FlushD, FlushE out 1 each
MduBusy out 1 MDU result not yet valid

Behaviour:
- Decoded ops: R-type (op 0) add 20h, sub 22h, and 24h, or 25h, slt 2Ah, mult 18h, div 1Ah, mfhi 10h, mflo 12h, jr 08h. I/J-type: lw 23h, sw 2Bh, beq 04h, bne 05h, addi 08h, ori 0Dh, j 02h, jal 03h.
- Unknown opcode or funct decodes to all-zero controls (NOP).
- UsesRsD / UsesRtD are decoded per instruction; hazard compares ignore unused sources.
- D/E register is floprc-style: FlushE or reset clears it to 0. E/M and M/W clear on reset only.
- Reset value of every output is 0, including registered controls, MduBusy, stalls and flushes. MDU FSM resets to IDLE with count 0.
- A register index of 0 never matches in any hazard or forward compare.
- ForwardAE = 10 if RsE==WriteRegM & RegWriteM; else 01 if RsE==WriteRegW & RegWriteW; else 00. M has priority. ForwardBE is the same using RtE.
- ForwardAD = RsD==WriteRegM & RegWriteM. ForwardBD is the same using RtD.
- lwstall = MemtoRegE & ((UsesRsD & RsD==RtE) | (UsesRtD & RtD==RtE)).
- branchstall = (BranchD|JrD) & an operand hits either:
  - WriteRegE with RegWriteE, or
  - WriteRegM with MemtoRegM.
- MDU FSM states IDLE and BUSY:
  - IDLE to BUSY when MduStartE = 1; count loads LAT-1, LAT selected by MduDivE.
  - In BUSY, count decrements each cycle. At count==0, BUSY returns to IDLE.
  - BUSY therefore lasts exactly LAT cycles.
- MduBusy = (state==BUSY) | MduStartE.
- mdustall = MduBusy & D-stage instruction is mfhi, mflo, mult or div.
- StallF = StallD = lwstall | branchstall | mdustall. FlushE = StallD.
- PCSrcD = (beqD & EqualD) | (bneD & ~EqualD).
- FlushD = ~DELAY_SLOT & ~StallD & (PCSrcD | JumpD | JrD).
- Simultaneous stall and redirect: the stall wins, and the redirect is re-evaluated next cycle.
- Reset mid-MDU-operation: the FSM aborts to IDLE immediately.

Decomposition:
- Package mips_pkg: opcode and funct localparams, ALU control codes, RegDst and ResultSrc encodings.
- One sub-module mdu_fsm: IDLE/BUSY state plus counter; inputs MduStartE and MduDivE, output MduBusy.
- Decode and hazard logic stay inline. Pipeline registers reuse the existing flopr/floprc.

Test Plan:
- add $3 in E, then sub using $3 in D -> ForwardAE=10 next cycle. With add in W instead -> ForwardAE=01. Writes to $0 -> forwarding stays 00.
- lw $2 in E while D = add $4,$2,$5 -> StallF=StallD=FlushE=1 for 1 cycle, then ForwardAE=01. D = j $2 -> no stall, since Rs is unused.
- beq $1,$1 with EqualD=1 -> PCSrcD=1, and FlushD=1 for DELAY_SLOT=0 / 0 for DELAY_SLOT=1. bne with EqualD=1 -> PCSrcD=0.
- mult (MULT_LAT=4) followed by mflo -> MduStartE pulse, then mdustall for 5 cycles. mflo enters E on the 6th cycle, and later ResultSrcW=11 with HiSelW=0.
- div then mult back-to-back (DIV_LAT=32) -> mult held in D for 33 cycles; exactly one MduStartE per op.
- reset asserted during MDU BUSY -> next cycle MduBusy=0, all stall and control outputs 0, FSM IDLE.
